// File: rtl/of_pkg.sv
// of_pkg: shared widths, tensor component order and fill-state encoding for the optical-flow chain
package of_pkg;
  localparam int DEF_TENSOR_WIDTH = 24;
  localparam int XX = 5;
  localparam int XY = 4;
  localparam int XT = 3;
  localparam int YY = 2;
  localparam int YT = 1;
  localparam int TT = 0;
  typedef logic signed [DEF_TENSOR_WIDTH-1:0] tensor_t;
  typedef enum logic {FILL, RUN} state_t;
endpackage

// File: rtl/tensor_window_sum.sv
// tensor_window_sum: one tensor component's sliding-window sum over a circular product buffer
module tensor_window_sum #(
  parameter int PROD_WIDTH = 18,
  parameter int ACC_WIDTH  = 24,
  parameter int WINDOW     = 5,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         restart_i,
  input  logic [PTR_WIDTH-1:0]         ptr_i,
  input  logic signed [PROD_WIDTH-1:0] prod_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);
  logic signed [PROD_WIDTH-1:0] win_q [WINDOW];
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  // A restart discards the whole window so rows never mix
  always_comb acc_d = restart_i ? ACC_WIDTH'(prod_i)
                                : acc_q + ACC_WIDTH'(prod_i) - ACC_WIDTH'(win_q[ptr_i]);
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      win_q <= '{default: '0};
    end else if (en_i) begin
      acc_q <= acc_d;
      for (int i = 0; i < WINDOW; i++)
        win_q[i] <= (PTR_WIDTH'(i) == ptr_i) ? prod_i : (restart_i ? '0 : win_q[i]);
    end
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/structure_tensor_builder.sv
// structure_tensor_builder: per-pixel gradient products summed over a WINDOW-pixel row window
module structure_tensor_builder
  import of_pkg::*;
#(
  parameter int GRAD_WIDTH   = 9,
  parameter int TENSOR_WIDTH = DEF_TENSOR_WIDTH,
  parameter int WINDOW       = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           line_start,
  input  logic signed [GRAD_WIDTH-1:0]   gx,
  input  logic signed [GRAD_WIDTH-1:0]   gy,
  input  logic signed [GRAD_WIDTH-1:0]   gt,
  output logic signed [TENSOR_WIDTH-1:0] xx,
  output logic signed [TENSOR_WIDTH-1:0] xy,
  output logic signed [TENSOR_WIDTH-1:0] xt,
  output logic signed [TENSOR_WIDTH-1:0] yy,
  output logic signed [TENSOR_WIDTH-1:0] yt,
  output logic signed [TENSOR_WIDTH-1:0] tt,
  output logic                           valid
);
  localparam int PWID = 2 * GRAD_WIDTH;
  localparam int CW   = $clog2(WINDOW + 1);
  localparam int PW   = $clog2(WINDOW);
  if (2 * GRAD_WIDTH + $clog2(WINDOW + 1) > TENSOR_WIDTH || WINDOW < 2 || WINDOW > 16) begin : g_bad_params
    $error("structure_tensor_builder: illegal GRAD_WIDTH/TENSOR_WIDTH/WINDOW combination");
  end
  logic signed [PWID-1:0] prod_d [6];
  logic signed [PWID-1:0] prod_q [6];
  logic signed [TENSOR_WIDTH-1:0] acc [6];
  logic signed [TENSOR_WIDTH-1:0] out_q [6];
  logic ls_p_q, pv_q, first_q, valid_q, adv;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  always_comb begin
    prod_d[XX] = PWID'(gx) * PWID'(gx);
    prod_d[XY] = PWID'(gx) * PWID'(gy);
    prod_d[XT] = PWID'(gx) * PWID'(gt);
    prod_d[YY] = PWID'(gy) * PWID'(gy);
    prod_d[YT] = PWID'(gy) * PWID'(gt);
    prod_d[TT] = PWID'(gt) * PWID'(gt);
  end
  // The accumulate stage only advances once the product stage holds a real sample
  assign adv = en & pv_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (adv) begin
      ptr_d   = (ptr_q == PW'(WINDOW - 1)) ? '0 : ptr_q + 1'b1;
      cnt_d   = ls_p_q ? CW'(1) : (cnt_q >= CW'(WINDOW - 1)) ? CW'(WINDOW) : cnt_q + 1'b1;
      state_d = (!ls_p_q && cnt_q >= CW'(WINDOW - 1)) ? RUN : FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '{default: '0};
      out_q   <= '{default: '0};
      ls_p_q  <= 1'b0;
      pv_q    <= 1'b0;
      first_q <= 1'b1;
      valid_q <= 1'b0;
      state_q <= FILL;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else if (en) begin
      prod_q  <= prod_d;
      ls_p_q  <= line_start | first_q;
      pv_q    <= 1'b1;
      first_q <= 1'b0;
      out_q   <= acc;
      valid_q <= (state_q == RUN);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end
  for (genvar c = 0; c < 6; c++) begin : g_sum
    tensor_window_sum #(
      .PROD_WIDTH(PWID),
      .ACC_WIDTH (TENSOR_WIDTH),
      .WINDOW    (WINDOW),
      .PTR_WIDTH (PW)
    ) u_sum (
      .clk      (clk),
      .rst      (rst),
      .en_i     (adv),
      .restart_i(ls_p_q),
      .ptr_i    (ptr_q),
      .prod_i   (prod_q[c]),
      .acc_o    (acc[c])
    );
  end
  assign xx    = out_q[XX];
  assign xy    = out_q[XY];
  assign xt    = out_q[XT];
  assign yy    = out_q[YY];
  assign yt    = out_q[YT];
  assign tt    = out_q[TT];
  assign valid = valid_q;
endmodule

// File: tb/tb_structure_tensor_builder.sv
// tb_structure_tensor_builder: scoreboard bench; a direct row-window model predicts each output
module tb_structure_tensor_builder;
  localparam int W = 5;
  logic clk = 1'b0;
  logic rst, en, line_start;
  logic signed [8:0] gx, gy, gt;
  logic signed [23:0] xx, xy, xt, yy, yt, tt;
  logic valid;
  wire [144:0] obs = {valid, xx, xy, xt, yy, yt, tt};
  int checks = 0;
  int failures = 0;
  int n = 0;
  int rcnt = 0;
  bit mfirst = 1'b1;
  int hx[$], hy[$], ht[$];
  logic [144:0] sb[$];
  structure_tensor_builder #(.GRAD_WIDTH(9), .TENSOR_WIDTH(24), .WINDOW(W)) dut (
    .clk(clk), .rst(rst), .en(en), .line_start(line_start),
    .gx(gx), .gy(gy), .gt(gt),
    .xx(xx), .xy(xy), .xt(xt), .yy(yy), .yt(yt), .tt(tt), .valid(valid)
  );
  always #5 clk = ~clk;
  task automatic model_push(input bit ls, input int a, input int b, input int c);
    int sxx, sxy, sxt, syy, syt, stt;
    if (ls || mfirst) begin
      hx.delete(); hy.delete(); ht.delete();
      rcnt = 0;
    end
    mfirst = 1'b0;
    hx.push_back(a); hy.push_back(b); ht.push_back(c);
    rcnt++;
    if (hx.size() > W) begin
      void'(hx.pop_front()); void'(hy.pop_front()); void'(ht.pop_front());
    end
    sxx = 0; sxy = 0; sxt = 0; syy = 0; syt = 0; stt = 0;
    for (int i = 0; i < hx.size(); i++) begin
      sxx += hx[i] * hx[i]; sxy += hx[i] * hy[i]; sxt += hx[i] * ht[i];
      syy += hy[i] * hy[i]; syt += hy[i] * ht[i]; stt += ht[i] * ht[i];
    end
    sb.push_back({rcnt >= W, 24'(sxx), 24'(sxy), 24'(sxt), 24'(syy), 24'(syt), 24'(stt)});
  endtask
  task automatic step(input bit e, input bit ls, input int a, input int b, input int c,
                      output bit due, output logic [144:0] ex);
    en = e; line_start = ls; gx = 9'(a); gy = 9'(b); gt = 9'(c);
    if (e) model_push(ls, a, b, c);
    @(posedge clk); #1;
    due = 1'b0;
    ex = '0;
    if (e) begin
      n++;
      if (n >= 3) begin
        ex = sb.pop_front();
        due = 1'b1;
      end
    end
  endtask
  task automatic do_reset(input bit e);
    rst = 1'b1; en = e; line_start = 1'b0; gx = 9'd7; gy = 9'd7; gt = 9'd7;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete(); hx.delete(); hy.delete(); ht.delete();
    n = 0; rcnt = 0; mfirst = 1'b1;
  endtask
  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if (obs !== 145'd0) begin
      failures++;
      $display("FAIL reset: got %h want 0", obs);
    end
  endtask
  task automatic test_constant();
    bit due; logic [144:0] ex;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, k == 0, 3, -2, 1, due, ex);
      if (due) begin
        checks++;
        if (obs !== ex) begin failures++; $display("FAIL constant[%0d]: got %h want %h", k, obs, ex); end
      end
    end
    checks++;
    if (obs !== {1'b1, 24'd45, -24'sd30, 24'd15, 24'd20, -24'sd10, 24'd5}) begin
      failures++;
      $display("FAIL constant_steady: got %h want xx=45 xy=-30 xt=15 yy=20 yt=-10 tt=5 valid=1", obs);
    end
  endtask
  task automatic test_ramp();
    bit due; logic [144:0] ex;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, k == 0, (k < 10) ? k + 1 : 0, 0, 0, due, ex);
      if (due) begin
        checks++;
        if (obs !== ex) begin failures++; $display("FAIL ramp[%0d]: got %h want %h", k, obs, ex); end
      end
    end
  endtask
  task automatic test_extremes();
    bit due; logic [144:0] ex;
    for (int k = 0; k < 7; k++) begin
      step(1'b1, k == 0, (k < 5) ? -256 : 0, (k < 5) ? -256 : 0, (k < 5) ? -256 : 0, due, ex);
      if (due) begin
        checks++;
        if (obs !== ex) begin failures++; $display("FAIL extremes[%0d]: got %h want %h", k, obs, ex); end
      end
    end
    checks++;
    if (obs !== {1'b1, {6{24'd327680}}}) begin
      failures++;
      $display("FAIL extremes_peak: got %h want all 327680 valid=1", obs);
    end
  endtask
  task automatic test_line_start();
    bit due; logic [144:0] ex;
    for (int k = 0; k < 15; k++) begin
      step(1'b1, k == 0 || k == 7, 2, 0, 0, due, ex);
      if (due) begin
        checks++;
        if (obs !== ex) begin failures++; $display("FAIL line_start[%0d]: got %h want %h", k, obs, ex); end
      end
    end
  endtask
  task automatic test_en_toggle();
    bit due; logic [144:0] ex;
    int k = 0;
    int guard = 0;
    while (k < 12 && guard < 200) begin
      guard++;
      if ($urandom_range(1) == 0) begin
        step(1'b0, 1'($urandom_range(1)), int'($urandom_range(511)) - 256,
             int'($urandom_range(511)) - 256, int'($urandom_range(511)) - 256, due, ex);
      end else begin
        step(1'b1, k == 0, (k < 10) ? k + 1 : 0, 0, 0, due, ex);
        k++;
      end
      if (due) begin
        checks++;
        if (obs !== ex) begin failures++; $display("FAIL en_toggle[%0d]: got %h want %h", k, obs, ex); end
      end
    end
    checks++;
    if (k != 12) begin
      failures++;
      $display("FAIL en_toggle_budget: got %0d samples want 12", k);
    end
  endtask
  task automatic test_back_to_back();
    bit due; logic [144:0] ex;
    for (int k = 0; k < 9; k++) begin
      step(1'b1, k < 2, 5 - k, k, -k, due, ex);
      if (due) begin
        checks++;
        if (obs !== ex) begin failures++; $display("FAIL back_to_back[%0d]: got %h want %h", k, obs, ex); end
      end
    end
  endtask
  task automatic test_reset_mid_row();
    bit due; logic [144:0] ex;
    for (int k = 0; k < 3; k++) step(1'b1, k == 0, 4, 4, 4, due, ex);
    do_reset(1'b1);
    checks++;
    if (obs !== 145'd0) begin
      failures++;
      $display("FAIL reset_mid_row: got %h want 0", obs);
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 3, -2, 1, due, ex);
      if (due) begin
        checks++;
        if (obs !== ex) begin failures++; $display("FAIL refill[%0d]: got %h want %h", k, obs, ex); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_extremes();
    test_line_start();
    test_en_toggle();
    test_back_to_back();
    test_reset_mid_row();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
